// File: rtl/bit_16_seq_subtractor_pkg.sv
// Shared definitions for the nibble-serial 16-bit subtractor: FSM encoding and slice width.
package bit_16_seq_subtractor_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bit_16_seq_subtractor_cla_slice.sv
// 4-bit carry-lookahead adder slice with group propagate/generate outputs.
module bit_4_cla_slice
  import bit_16_seq_subtractor_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout,
  output logic             p,
  output logic             g
);

  logic [NIB_W-1:0] prop;
  logic [NIB_W-1:0] gen;
  logic [NIB_W-1:0] c;

  assign prop = a ^ b;
  assign gen  = a & b;

  // Every internal carry is expanded from cin directly, so there is no ripple path.
  assign c[0] = cin;
  assign c[1] = gen[0] | (prop[0] & cin);
  assign c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin);
  assign c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
              | (prop[2] & prop[1] & prop[0] & cin);

  assign p    = &prop;
  assign g    = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
              | (prop[3] & prop[2] & prop[1] & gen[0]);
  assign cout = g | (p & cin);
  assign s    = prop ^ c;

endmodule

// File: rtl/bit_16_seq_subtractor.sv
// Multi-cycle subtractor: D = A - B - bin computed one nibble per clock as A + ~B + ~bin.
module bit_16_seq_subtractor
  import bit_16_seq_subtractor_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NIB_W*NIBBLES-1:0] A,
  input  logic [NIB_W*NIBBLES-1:0] B,
  input  logic                     bin,
  output logic                     busy,
  output logic                     done,
  output logic [NIB_W*NIBBLES-1:0] D,
  output logic                     bout
);

  localparam int W     = NIB_W * NIBBLES;
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  state_t           state;
  logic [W-1:0]     a_r;
  logic [W-1:0]     bn_r;
  logic             c;
  logic [CNT_W-1:0] k;

  logic [NIB_W-1:0] a_nib;
  logic [NIB_W-1:0] b_nib;
  logic [NIB_W-1:0] s;
  logic             c_next;
  logic             slice_p;
  logic             slice_g;
  logic             unused_pg;

  assign a_nib = a_r[k*NIB_W +: NIB_W];
  assign b_nib = bn_r[k*NIB_W +: NIB_W];

  bit_4_cla_slice u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (c),
    .s    (s),
    .cout (c_next),
    .p    (slice_p),
    .g    (slice_g)
  );

  // Group p/g are kept on the slice for wider lookahead reuse; the serial chain only needs cout.
  assign unused_pg = slice_p & slice_g;

  // NOTE: all state here uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: operand registers are plain flops, not a memory array, so resetting them is cheap and deterministic.
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      D     <= '0;
      bout  <= 1'b0;
      a_r   <= '0;
      bn_r  <= '0;
      c     <= 1'b0;
      k     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          k    <= '0;
          if (start) begin
            a_r   <= A;
            bn_r  <= ~B;
            c     <= ~bin;
            busy  <= 1'b1;
            state <= S_CALC;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          D[k*NIB_W +: NIB_W] <= s;
          c <= c_next;
          if (k == LAST) begin
            bout  <= ~c_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_16_seq_subtractor.sv
// Self-checking bench: arithmetic/timeline model plus directed literals and random operations.
module tb_bit_16_seq_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        bin;
  logic        busy;
  logic        done;
  logic [15:0] D;
  logic        bout;

  int total = 0;
  int bad   = 0;

  bit_16_seq_subtractor #(.NIBBLES(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .D    (D),
    .bout (bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1..4 busy, 5 done; the result is plain integer subtraction.
  int          phase = 0;
  bit          model_valid = 1'b0;
  logic [15:0] m_d = '0;
  logic        m_bout = 1'b0;
  logic [15:0] pend_d;
  logic        pend_b;

  always @(posedge clk) begin
    if (rst) begin
      phase       = 0;
      m_d         = '0;
      m_bout      = 1'b0;
      model_valid = 1'b1;
    end else if (phase >= 1 && phase <= 4) begin
      if (phase == 4) begin
        m_d    = pend_d;
        m_bout = pend_b;
      end
      phase++;
    end else if (start) begin
      int diff;
      diff   = int'(A) - int'(B) - int'(bin);
      pend_d = diff[15:0];
      pend_b = (diff < 0);
      phase  = 1;
    end else begin
      phase = 0;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("busy", 32'(busy), 32'(phase >= 1 && phase <= 4));
      check("done", 32'(done), 32'(phase == 5));
      if (phase == 0 || phase == 5) begin
        check("d_model", 32'(D), 32'(m_d));
        check("bout_model", 32'(bout), 32'(m_bout));
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic bi);
    A     = a;
    B     = b;
    bin   = bi;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns at the negedge where done is high; cycles counts negedges waited.
  task automatic wait_done(output int cycles);
    cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cycles++;
      if (done) return;
    end
    check("done_timeout", 32'(cycles), 32'd0);
  endtask

  task automatic op_literal(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic bi, input logic [15:0] exp_d, input logic exp_b);
    int cyc;
    issue(a, b, bi);
    wait_done(cyc);
    check({name, "_lat"}, 32'(cyc), 32'd5);
    check({name, "_d"}, 32'(D), 32'(exp_d));
    check({name, "_bout"}, 32'(bout), 32'(exp_b));
  endtask

  initial begin
    int cyc;
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    bin   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_d", 32'(D), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;

    op_literal("neg", 16'd65000, 16'd65340, 1'b0, 16'd65196, 1'b1);

    // Back-to-back: second start is driven in the DONE cycle.
    op_literal("b2b_first", 16'd58135, 16'd3592, 1'b0, 16'd54543, 1'b0);
    issue(16'd1005, 16'd69, 1'b1);
    wait_done(cyc);
    check("b2b_lat", 32'(cyc), 32'd5);
    check("b2b_d", 32'(D), 32'd935);
    check("b2b_bout", 32'(bout), 32'd0);

    // Start and operand changes while busy must be ignored.
    @(posedge clk);
    #1;
    issue(16'd15124, 16'd5383, 1'b1);
    @(posedge clk);
    #1 start = 1'b1;
    A = 16'hDEAD;
    B = 16'h0001;
    bin = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc);
    check("ign_d", 32'(D), 32'd9740);
    check("ign_bout", 32'(bout), 32'd0);

    // Reset during the second CALC cycle aborts without a done pulse.
    @(posedge clk);
    #1;
    issue(16'd50, 16'd10024, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_done", 32'(done), 32'd0);
    end
    check("abort_d", 32'(D), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    @(posedge clk);
    #1;
    op_literal("reissue", 16'd50, 16'd10024, 1'b0, 16'd55562, 1'b1);

    @(posedge clk);
    #1;
    op_literal("c_all_ones", 16'd0, 16'd0, 1'b1, 16'hFFFF, 1'b1);
    @(posedge clk);
    #1;
    op_literal("c_equal", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0);
    @(posedge clk);
    #1;
    op_literal("c_max", 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0);

    // Random operations; half are issued back-to-back from the DONE cycle.
    for (int n = 0; n < 200; n++) begin
      issue(16'($urandom), 16'($urandom), 1'($urandom));
      wait_done(cyc);
      check("rand_lat", 32'(cyc), 32'd5);
      if ($urandom_range(1, 0) == 0) begin
        @(posedge clk);
        #1;
        repeat ($urandom_range(2, 0)) begin
          @(posedge clk);
          #1;
        end
      end
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_16_seq_subtractor.md
Name: bit_16_seq_subtractor

Overview:
Multi-cycle 16-bit unsigned subtractor with borrow-in and borrow-out. It is the inverse-direction companion to the team's 16-bit lookahead adder. Computes D = A - B - bin one 4-bit nibble per clock, reusing a 4-bit carry-lookahead slice. It sits behind a start/busy/done handshake, so the ALU controller can issue operations without a wide combinational path.

Parameters:
NIBBLES, 4, number of 4-bit slices processed; fixes the width at 4*NIBBLES = 16 bits.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only when busy=0
A  input  16  minuend, captured on accepted start
B  input  16  subtrahend, captured on accepted start
bin  input  1  borrow-in, captured on accepted start
busy  output  1  high while an operation is in progress (state CALC)
done  output  1  single-cycle pulse: D/bout valid
D  output  16  difference (A - B - bin) mod 2^16
bout  output  1  borrow-out: 1 when A < B + bin

Behaviour:
- Reset (rst=1 at a rising edge) forces:
  - state=IDLE, busy=0, done=0, D=16'd0, bout=0
  - internal operand registers, carry register and nibble counter to 0
- Reset takes priority over everything, including mid-CALC; the aborted operation produces no done pulse.
- Arithmetic is two's-complement addition:
  - capture A_r=A, Bn_r=~B, c=~bin
  - each CALC cycle k (k=0..3) computes {c_next, s} = A_r[4k+3:4k] + Bn_r[4k+3:4k] + c via the slice
  - write s into D[4k+3:4k] and set c <= c_next
- Final result: bout = ~c after nibble 3.
- States:
  - IDLE: busy=0, done=0. start=1 captures operands, sets k=0 and moves to CALC.
  - CALC: busy=1. One nibble per cycle; k increments. The cycle processing k=3 moves to DONE.
  - DONE: busy=0, done=1 for exactly one cycle, bout valid. Next state is IDLE, or CALC if start=1, which allows back-to-back operations.
- Latency: start accepted at edge E0; nibbles written at E1..E4; done=1 in the cycle following E4. That is 4 cycles from accept to done and a throughput of 1 op per 5 cycles.
- D and bout hold their last result until the next operation begins writing. D is updated nibble-wise during CALC, so it is only meaningful when done=1 or afterwards in IDLE.
- start while busy=1 is ignored; it is not queued. A/B/bin changes during CALC have no effect.
- Boundaries:
  - A=B, bin=0 -> D=0, bout=0
  - A=0, B=0, bin=1 -> D=16'hFFFF, bout=1
  - A=16'hFFFF, B=0, bin=0 -> D=16'hFFFF, bout=0
- The counter wraps only via the state transition; k never exceeds 3.

Decomposition:
- Shared package: state encoding constants (S_IDLE=2'd0, S_CALC=2'd1, S_DONE=2'd2) and the slice width constant NIB_W=4.
- Sub-module bit_4_cla_slice:
  - inputs: a[3:0], b[3:0], cin
  - outputs: s[3:0], cout, p, g
  - combinational generate/propagate lookahead
  - the only instance; the FSM, counter and registers live in the top.

Test Plan:
- rst=1 for 2 cycles, then rst=0 -> D=0, bout=0, busy=0, done=0.
- A=65000, B=65340, bin=0, start pulse -> done after 4 cycles, D=65196, bout=1.
- A=58135, B=3592, bin=0 -> D=54543, bout=0. Then back-to-back start in the DONE cycle with A=1005, B=69, bin=1 -> D=935, bout=0 with no IDLE gap.
- A=15124, B=5383, bin=1 -> D=9740, bout=0. A second start and changed A/B during CALC are ignored; the result is unchanged.
- A=50, B=10024, bin=0; assert rst at the 2nd CALC cycle -> no done pulse, outputs 0. Re-issue the operation -> D=55562, bout=1.
- Corners: A=0, B=0, bin=1 -> D=16'hFFFF, bout=1. A=B=16'h8000, bin=0 -> D=0, bout=0.
